// File: rtl/spatial_encoder_scheduler_pkg.sv
// Shared constants, FSM encoding and helpers for the spatial encoder scheduler.
// No ports: imported by the arbiter and the top.
package spatial_encoder_scheduler_pkg;

  localparam int HV_DIMENSION = 64;
  localparam int DEF_NUM_MOD  = 3;
  localparam int DEF_NUM_CH   = 32;
  localparam int DEF_LEVEL_W  = 5;

  // Never returns 0 so single-entry fields still get a 1-bit port.
  function automatic int ceilLog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_DRAIN   = 2'd2,
    S_WAIT_HV = 2'd3
  } state_t;

endpackage

// File: rtl/spatial_encoder_scheduler_rr_arbiter.sv
// Round-robin arbiter: first request at/after the pointer wins.
// Ports: clk, rst, i_req (requests), i_take (grant consumed), o_gnt (one-hot), o_gnt_idx.
module spatial_encoder_scheduler_rr_arbiter
  import spatial_encoder_scheduler_pkg::*;
#(
  parameter  int N  = DEF_NUM_MOD,
  localparam int IW = ceilLog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  i_req,
  input  logic          i_take,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_gnt_idx
);

  logic [IW-1:0] r_ptr;

  always_comb begin
    logic found;
    int   j;
    found     = 1'b0;
    j         = 0;
    o_gnt     = '0;
    o_gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(r_ptr) + i;
      if (j >= N) j = j - N;
      if (!found && i_req[j]) begin
        found     = 1'b1;
        o_gnt[j]  = 1'b1;
        o_gnt_idx = IW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_take) begin
      r_ptr <= (o_gnt_idx == IW'(N - 1)) ? '0 : o_gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/spatial_encoder_scheduler.sv
// Time-shares one spatial encoder between NUM_MOD modalities, one whole sample per grant.
// Ports: i_smp_* sample requests, o_mem_*/i_*_rdata ROM fetch, o_enc_*/i_enc_* encoder, o_out_* tagged result.
module spatial_encoder_scheduler
  import spatial_encoder_scheduler_pkg::*;
#(
  parameter  int NUM_MOD = DEF_NUM_MOD,
  parameter  int NUM_CH  = DEF_NUM_CH,
  parameter  int LEVEL_W = DEF_LEVEL_W,
  parameter  int HV_DIM  = HV_DIMENSION,
  localparam int IM_AW   = ceilLog2(NUM_MOD * NUM_CH),
  localparam int MW      = ceilLog2(NUM_MOD),
  localparam int CW      = ceilLog2(NUM_CH),
  localparam int SW      = NUM_CH * LEVEL_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_MOD-1:0]         i_smp_valid,
  output logic [NUM_MOD-1:0]         o_smp_ready,
  input  logic [NUM_MOD*SW-1:0]      i_smp_levels,
  output logic                       o_mem_rd_en,
  output logic [IM_AW-1:0]           o_im_addr,
  output logic [LEVEL_W-1:0]         o_projm_addr,
  input  logic [HV_DIM-1:0]          i_im_rdata,
  input  logic [HV_DIM-1:0]          i_projm_rdata,
  output logic                       o_enc_din_valid,
  input  logic                       i_enc_din_ready,
  output logic [HV_DIM-1:0]          o_enc_im,
  output logic [HV_DIM-1:0]          o_enc_projm,
  input  logic                       i_enc_hv_valid,
  output logic                       o_enc_hv_ready,
  input  logic [HV_DIM-1:0]          i_enc_hv,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [HV_DIM-1:0]          o_out_hv,
  output logic [MW-1:0]              o_out_mod
);

  state_t              r_state;
  logic [CW-1:0]       r_ch;
  logic [MW-1:0]       r_mod;
  logic [SW-1:0]       r_levels;
  logic                r_rd_en;
  logic                r_din_vld;
  logic                r_out_vld;
  logic [HV_DIM-1:0]   r_out_hv;
  logic [MW-1:0]       r_out_mod;

  logic [NUM_MOD-1:0]  w_gnt;
  logic [MW-1:0]       w_gnt_idx;
  logic                w_grant_en;
  logic                w_hv_ready;
  logic                w_hv_fire;
  logic [SW-1:0]       w_sel_levels;

  // rst gate keeps a held-high request from seeing ready during reset.
  assign w_grant_en = (r_state == S_IDLE) && (|i_smp_valid)
                    && i_enc_din_ready && !rst;

  spatial_encoder_scheduler_rr_arbiter #(
    .N (NUM_MOD)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_smp_valid),
    .i_take    (w_grant_en),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  assign o_smp_ready  = w_grant_en ? w_gnt : '0;
  assign w_sel_levels = i_smp_levels[int'(w_gnt_idx)*SW +: SW];

  assign w_hv_ready = (r_state == S_WAIT_HV)
                    && (!r_out_vld || i_out_ready);
  assign w_hv_fire  = w_hv_ready && i_enc_hv_valid;

  assign o_mem_rd_en     = r_rd_en;
  assign o_im_addr       = IM_AW'(int'(r_mod) * NUM_CH + int'(r_ch));
  assign o_projm_addr    = r_levels[int'(r_ch)*LEVEL_W +: LEVEL_W];
  assign o_enc_din_valid = r_din_vld;
  assign o_enc_im        = i_im_rdata;
  assign o_enc_projm     = i_projm_rdata;
  assign o_enc_hv_ready  = w_hv_ready;
  assign o_out_valid     = r_out_vld;
  assign o_out_hv        = r_out_hv;
  assign o_out_mod       = r_out_mod;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ch      <= '0;
      r_mod     <= '0;
      r_levels  <= '0;
      r_rd_en   <= 1'b0;
      r_din_vld <= 1'b0;
      r_out_vld <= 1'b0;
      r_out_hv  <= '0;
      r_out_mod <= '0;
    end else begin
      // ROM data lands one cycle after the read, so din_valid trails rd_en.
      r_din_vld <= r_rd_en;
      if (r_out_vld && i_out_ready) r_out_vld <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_grant_en) begin
            r_mod    <= w_gnt_idx;
            r_levels <= w_sel_levels;
            r_ch     <= '0;
            r_rd_en  <= 1'b1;
            r_state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (r_ch == CW'(NUM_CH - 1)) begin
            r_ch    <= '0;
            r_rd_en <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            r_ch <= r_ch + 1'b1;
          end
        end
        S_DRAIN: begin
          r_state <= S_WAIT_HV;
        end
        S_WAIT_HV: begin
          if (w_hv_fire) begin
            r_out_vld <= 1'b1;
            r_out_hv  <= i_enc_hv;
            r_out_mod <= r_mod;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  // The encoder must take every beat of a sample without back-pressure.
  a_din_ready : assert property (
    @(posedge clk) disable iff (rst) r_din_vld |-> i_enc_din_ready
  );
`endif

endmodule

// File: tb/tb_spatial_encoder_scheduler.sv
// Directed bench for spatial_encoder_scheduler with ROM and encoder models.
// Ports: none.
module tb_spatial_encoder_scheduler;

  localparam int NUM_MOD = 3;
  localparam int NUM_CH  = 32;
  localparam int LEVEL_W = 5;
  localparam int HV      = 64;
  localparam int IM_AW   = 7;
  localparam int MW      = 2;
  localparam int LVW     = NUM_MOD * NUM_CH * LEVEL_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NUM_MOD-1:0] smp_valid = '0;
  logic [NUM_MOD-1:0] smp_ready;
  logic [LVW-1:0]    smp_levels = '0;
  logic              mem_rd_en;
  logic [IM_AW-1:0]  im_addr;
  logic [LEVEL_W-1:0] projm_addr;
  logic [HV-1:0]     im_rdata = '0;
  logic [HV-1:0]     projm_rdata = '0;
  logic              enc_din_valid;
  logic              enc_din_ready = 1'b1;
  logic [HV-1:0]     enc_im;
  logic [HV-1:0]     enc_projm;
  logic              enc_hv_valid = 1'b0;
  logic              enc_hv_ready;
  logic [HV-1:0]     enc_hv = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [HV-1:0]     out_hv;
  logic [MW-1:0]     out_mod;

  always #5 clk = ~clk;

  spatial_encoder_scheduler #(
    .NUM_MOD (NUM_MOD),
    .NUM_CH  (NUM_CH),
    .LEVEL_W (LEVEL_W),
    .HV_DIM  (HV)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_smp_valid     (smp_valid),
    .o_smp_ready     (smp_ready),
    .i_smp_levels    (smp_levels),
    .o_mem_rd_en     (mem_rd_en),
    .o_im_addr       (im_addr),
    .o_projm_addr    (projm_addr),
    .i_im_rdata      (im_rdata),
    .i_projm_rdata   (projm_rdata),
    .o_enc_din_valid (enc_din_valid),
    .i_enc_din_ready (enc_din_ready),
    .o_enc_im        (enc_im),
    .o_enc_projm     (enc_projm),
    .i_enc_hv_valid  (enc_hv_valid),
    .o_enc_hv_ready  (enc_hv_ready),
    .i_enc_hv        (enc_hv),
    .o_out_valid     (out_valid),
    .i_out_ready     (out_ready),
    .o_out_hv        (out_hv),
    .o_out_mod       (out_mod)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] im_rom(input int a);
    logic [63:0] x;
    x = 64'h9E3779B97F4A7C15 * 64'(a + 1);
    return x ^ (x >> 29);
  endfunction

  function automatic logic [63:0] pm_rom(input int l);
    logic [63:0] x;
    x = 64'hC2B2AE3D27D4EB4F * 64'(l + 7);
    return x ^ (x >> 31);
  endfunction

  function automatic logic [63:0] bind_hv(input logic [63:0] a,
                                          input logic [63:0] p);
    return a ^ {p[0], p[63:1]};
  endfunction

  function automatic logic [63:0] golden(input int m,
                                         input logic [LVW-1:0] lv);
    int cnt[64];
    logic [63:0] v;
    logic [63:0] r;
    logic [LEVEL_W-1:0] l;
    for (int b = 0; b < 64; b++) cnt[b] = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      l = lv[(m*NUM_CH+c)*LEVEL_W +: LEVEL_W];
      v = bind_hv(im_rom(m*NUM_CH + c), pm_rom(int'(l)));
      for (int b = 0; b < 64; b++) cnt[b] += int'(v[b]);
    end
    for (int b = 0; b < 64; b++) r[b] = (cnt[b] > NUM_CH/2);
    return r;
  endfunction

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic int oh2i(input logic [NUM_MOD-1:0] v);
    for (int i = 0; i < NUM_MOD; i++) if (v[i]) return i;
    return -1;
  endfunction

  // ROM model: 1-cycle read latency
  always @(posedge clk) begin
    if (mem_rd_en) begin
      im_rdata    <= im_rom(int'(im_addr));
      projm_rdata <= pm_rom(int'(projm_addr));
    end
  end

  // Encoder model: majority bundle, hvout_valid 3 cycles after last beat
  int acc[64];
  int enc_nb;
  int enc_dly;
  logic [63:0] enc_v;
  logic [63:0] enc_r;
  always @(posedge clk) begin
    if (rst) begin
      enc_nb = 0;
      enc_dly = 0;
      for (int b = 0; b < 64; b++) acc[b] = 0;
      enc_din_ready <= 1'b1;
      enc_hv_valid  <= 1'b0;
      enc_hv        <= '0;
    end else begin
      if (enc_hv_valid && enc_hv_ready) begin
        enc_hv_valid  <= 1'b0;
        enc_din_ready <= 1'b1;
      end
      if (enc_din_valid && enc_din_ready) begin
        enc_v = bind_hv(enc_im, enc_projm);
        for (int b = 0; b < 64; b++) acc[b] += int'(enc_v[b]);
        enc_nb++;
        if (enc_nb == NUM_CH) begin
          enc_din_ready <= 1'b0;
          enc_dly = 2;
        end
      end else if (enc_dly != 0) begin
        if (enc_dly == 1) begin
          for (int b = 0; b < 64; b++) begin
            enc_r[b] = (acc[b] > NUM_CH/2);
            acc[b] = 0;
          end
          enc_nb = 0;
          enc_hv       <= enc_r;
          enc_hv_valid <= 1'b1;
        end
        enc_dly--;
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Requesters: valid stays up while a modality has pending samples
  int pend[NUM_MOD] = '{0, 0, 0};
  logic [NUM_MOD-1:0] hs;
  initial begin
    forever begin
      @(negedge clk);
      hs = smp_valid & smp_ready;
      @(posedge clk);
      #2;
      for (int m = 0; m < NUM_MOD; m++) begin
        if (hs[m] && pend[m] > 0) pend[m]--;
        smp_valid[m] = (pend[m] > 0);
      end
    end
  end

  int g_q[$];
  int g_cyc[$];
  int hvf_cyc[$];
  int ov_rise[$];
  int ia_q[$];
  int pa_q[$];
  int exp_m[$];
  logic [63:0] exp_h[$];
  int n_out, din_cnt, din_first, viol, stall_err, mon_m;
  logic ov_d, st_prev;
  logic [63:0] st_hv;
  logic [MW-1:0] st_mod;

  initial begin
    n_out = 0; din_cnt = 0; din_first = 0; viol = 0; stall_err = 0;
    mon_m = 0; ov_d = 0; st_prev = 0; st_hv = '0; st_mod = '0;
  end

  always @(negedge clk) begin
    if (rst) begin
      exp_h.delete();
      exp_m.delete();
      ov_d = 1'b0;
      st_prev = 1'b0;
    end else begin
      if (smp_ready != '0) begin
        mon_m = oh2i(smp_ready);
        g_q.push_back(mon_m);
        g_cyc.push_back(cyc);
        exp_h.push_back(golden(mon_m, smp_levels));
        exp_m.push_back(mon_m);
      end
      if (mem_rd_en) begin
        ia_q.push_back(int'(im_addr));
        pa_q.push_back(int'(projm_addr));
      end
      if (enc_din_valid) begin
        if (din_cnt == 0) din_first = cyc;
        din_cnt++;
      end
      if (enc_din_valid && !enc_din_ready) viol++;
      if (enc_hv_valid && enc_hv_ready) hvf_cyc.push_back(cyc);
      if (out_valid && !ov_d) ov_rise.push_back(cyc);
      if (st_prev && (!out_valid || out_hv != st_hv || out_mod != st_mod))
        stall_err++;
      if (out_valid && out_ready) begin
        if (exp_h.size() == 0) chk("out_extra", 1, 0);
        else begin
          chk("out_mod", 64'(out_mod), 64'(exp_m.pop_front()));
          chk("out_hv", out_hv, exp_h.pop_front());
        end
        n_out++;
      end
      st_prev = out_valid && !out_ready;
      st_hv   = out_hv;
      st_mod  = out_mod;
      ov_d    = out_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    g_q.delete(); g_cyc.delete(); hvf_cyc.delete(); ov_rise.delete();
    ia_q.delete(); pa_q.delete();
    n_out = 0; din_cnt = 0; viol = 0; stall_err = 0;
  endtask

  task automatic do_reset();
    for (int m = 0; m < NUM_MOD; m++) pend[m] = 0;
    out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    clr();
  endtask

  task automatic set_lv(input int m, input int c, input int v);
    smp_levels[(m*NUM_CH+c)*LEVEL_W +: LEVEL_W] = LEVEL_W'(v);
  endtask

  task automatic wait_outs(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (n_out < n && k < budget) begin
      step();
      k++;
    end
    chk(tag, 64'(n_out), 64'(n));
  endtask

  int e1, e2, k;
  int exp2[4] = '{0, 1, 2, 0};
  logic [63:0] hv_a;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("rst_smp_ready", 64'(smp_ready), 0);
    chk("rst_rd_en", 64'(mem_rd_en), 0);
    chk("rst_din_valid", 64'(enc_din_valid), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_hv", out_hv, 0);
    chk("rst_out_mod", 64'(out_mod), 0);

    // T1: single sample on mod 1, all levels 3
    for (int c = 0; c < NUM_CH; c++) set_lv(1, c, 3);
    pend[1] = 1;
    wait_outs("t1_outs", 1, 200);
    chk("t1_ngrant", 64'(g_q.size()), 1);
    chk("t1_grant_mod", 64'(at(g_q, 0)), 1);
    chk("t1_nreads", 64'(ia_q.size()), NUM_CH);
    e1 = 0; e2 = 0;
    for (int i = 0; i < ia_q.size(); i++) begin
      if (ia_q[i] != 32 + i) e1++;
      if (pa_q[i] != 3) e2++;
    end
    chk("t1_im_addr_errs", 64'(e1), 0);
    chk("t1_projm_errs", 64'(e2), 0);
    chk("t1_im_first", 64'(at(ia_q, 0)), 32);
    chk("t1_din_beats", 64'(din_cnt), NUM_CH);
    chk("t1_din_lat", 64'(din_first - at(g_cyc, 0)), 2);
    chk("t1_hv_lat", 64'(at(hvf_cyc, 0) - at(g_cyc, 0)), NUM_CH + 4);
    chk("t1_out_lat", 64'(at(ov_rise, 0) - at(g_cyc, 0)), NUM_CH + 5);

    // T2: all three held high, order 0,1,2,0
    do_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      set_lv(0, c, c);
      set_lv(1, c, (c * 7) % 32);
      set_lv(2, c, 31 - c);
    end
    pend[0] = 2; pend[1] = 1; pend[2] = 1;
    wait_outs("t2_outs", 4, 600);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t2_grant%0d", i), 64'(at(g_q, i)), 64'(exp2[i]));
    chk("t2_pend_left", 64'(pend[0] + pend[1] + pend[2]), 0);

    // T3: downstream stall for 100 cycles
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < NUM_CH; c++) set_lv(2, c, (c * 3) % 32);
    hv_a = golden(2, smp_levels);
    pend[2] = 1;
    k = 0;
    while (g_q.size() < 1 && k < 20) begin step(); k++; end
    step();
    for (int c = 0; c < NUM_CH; c++) set_lv(2, c, (c * 5 + 1) % 32);
    pend[2] = 1;
    k = 0;
    while (!out_valid && k < 100) begin step(); k++; end
    chk("t3_first_valid", 64'(out_valid), 1);
    repeat (100) step();
    chk("t3_hv_ready", 64'(enc_hv_ready), 0);
    chk("t3_enc_waiting", 64'(enc_hv_valid), 1);
    chk("t3_out_held", 64'(out_valid), 1);
    chk("t3_out_hv_held", out_hv, hv_a);
    chk("t3_stall_errs", 64'(stall_err), 0);
    chk("t3_no_early_out", 64'(n_out), 0);
    out_ready = 1'b1;
    wait_outs("t3_outs", 2, 100);

    // T4: reset during fetch at channel 10
    do_reset();
    for (int c = 0; c < NUM_CH; c++) set_lv(0, c, c % 7);
    pend[0] = 1;
    k = 0;
    while (!(mem_rd_en && im_addr == 10) && k < 50) begin step(); k++; end
    chk("t4_reach_ch10", 64'(mem_rd_en && im_addr == 10), 1);
    rst = 1'b1;
    step();
    chk("t4_rd_en", 64'(mem_rd_en), 0);
    chk("t4_din_valid", 64'(enc_din_valid), 0);
    chk("t4_out_valid", 64'(out_valid), 0);
    chk("t4_hv_ready", 64'(enc_hv_ready), 0);
    chk("t4_im_addr", 64'(im_addr), 0);
    chk("t4_out_hv", out_hv, 0);
    rst = 1'b0;
    repeat (60) step();
    chk("t4_no_out", 64'(n_out), 0);
    for (int c = 0; c < NUM_CH; c++) set_lv(0, c, 31 - c);
    pend[0] = 1;
    wait_outs("t4_fresh_out", 1, 100);

    // T5: levels 0/31 alternating
    do_reset();
    for (int c = 0; c < NUM_CH; c++) set_lv(0, c, (c % 2 == 1) ? 31 : 0);
    pend[0] = 1;
    wait_outs("t5_outs", 1, 100);
    chk("t5_nreads", 64'(pa_q.size()), NUM_CH);
    e1 = 0;
    for (int i = 0; i < pa_q.size(); i++)
      if (pa_q[i] != ((i % 2 == 1) ? 31 : 0)) e1++;
    chk("t5_projm_errs", 64'(e1), 0);
    chk("t5_projm_1", 64'(at(pa_q, 1)), 31);
    chk("t5_im_last", 64'(at(ia_q, NUM_CH - 1)), NUM_CH - 1);

    // T6: back-to-back on mod 0
    do_reset();
    for (int c = 0; c < NUM_CH; c++) set_lv(0, c, (c * 2) % 32);
    pend[0] = 2;
    wait_outs("t6_outs", 2, 200);
    chk("t6_ngrant", 64'(g_q.size()), 2);
    chk("t6_regrant", 64'(at(g_cyc, 1) - at(hvf_cyc, 0)), 1);
    chk("t6_protocol", 64'(viol), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
